// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - fetch lookup and execute training bundle for btb_predictor
//
// Signals (master = core side, slave = predictor):
//   flush              clear all BTB valid bits and empty the RAS
//   lk_pc              fetch PC to look up
//   pred_taken         predicted redirect
//   pred_target        predicted next PC, 0 on a miss
//   pred_target_plus4  pred_target + 4 (wraps)
//   upd_valid          resolved control-flow instruction this cycle
//   upd_pc             PC of the resolved instruction
//   upd_target         resolved target
//   upd_taken          resolved direction
//   upd_type           00 branch, 01 jump/indirect, 10 call, 11 return
interface btb_predictor_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic [XLEN-1:0] lk_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] pred_target_plus4;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic [1:0]      upd_type;

    modport master (
        output flush, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_type,
        input  pred_taken, pred_target, pred_target_plus4
    );

    modport slave (
        input  flush, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_type,
        output pred_taken, pred_target, pred_target_plus4
    );
endinterface

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB with 2-bit counters plus return address stack
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  btb_predictor_if slave: combinational lookup on lk_pc, training from execute
module btb_predictor #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    btb_predictor_if.slave bus
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;
    localparam int RASW = $clog2(RAS_DEPTH);
    localparam logic [RASW:0] RAS_FULL = (RASW+1)'(RAS_DEPTH);

    // Control state: reset asynchronously.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [RASW-1:0]    ras_ptr_q, ras_ptr_d;   // next write slot
    logic [RASW:0]      ras_cnt_q, ras_cnt_d;

    // Payload state: only meaningful behind valid / ras_cnt, so no reset.
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [TAGW-1:0]    tag_d    [ENTRIES];
    logic [XLEN-2:0]    target_q [ENTRIES];
    logic [XLEN-2:0]    target_d [ENTRIES];
    logic [1:0]         type_q   [ENTRIES];
    logic [1:0]         type_d   [ENTRIES];
    logic [XLEN-1:0]    ras_q    [RAS_DEPTH];
    logic [XLEN-1:0]    ras_d    [RAS_DEPTH];

    // ---------------- lookup ----------------
    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            unused_bits;

    assign lk_idx      = bus.lk_pc[IDXW+1:2];
    assign lk_tag      = bus.lk_pc[XLEN-1:IDXW+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign ras_top     = ras_q[ras_ptr_q - 1'b1];
    assign ras_empty   = (ras_cnt_q == '0);
    assign unused_bits = ^{bus.lk_pc[1:0], bus.upd_target[0]};

    always_comb begin
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        if (lk_hit) begin
            // Unconditional types always redirect; branches follow the counter MSB.
            bus.pred_taken = (type_q[lk_idx] != 2'b00) || ctr_q[lk_idx][1];
            if (type_q[lk_idx] == 2'b11 && !ras_empty)
                bus.pred_target = ras_top;
            else
                bus.pred_target = {target_q[lk_idx], 1'b0};
        end
    end

    assign bus.pred_target_plus4 = bus.pred_target + XLEN'(4);

    // ---------------- update ----------------
    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;
    logic            eff_taken;

    assign upd_idx   = bus.upd_pc[IDXW+1:2];
    assign upd_tag   = bus.upd_pc[XLEN-1:IDXW+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // Jumps, calls and returns are unconditional regardless of upd_taken.
    assign eff_taken = bus.upd_taken || (bus.upd_type != 2'b00);

    always_comb begin
        valid_d   = valid_q;
        ctr_d     = ctr_q;
        tag_d     = tag_q;
        target_d  = target_q;
        type_d    = type_q;
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;

        if (bus.flush) begin
            // Flush wins over a simultaneous update.
            valid_d   = '0;
            ras_ptr_d = '0;
            ras_cnt_d = '0;
        end else if (bus.upd_valid) begin
            if (upd_hit) begin
                if (eff_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                    target_d[upd_idx] = bus.upd_target[XLEN-1:1];
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
                type_d[upd_idx] = bus.upd_type;
            end else if (eff_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bus.upd_target[XLEN-1:1];
                type_d[upd_idx]   = bus.upd_type;
                ctr_d[upd_idx]    = 2'b10;
            end

            // Circular stack: a push when full overwrites the oldest slot.
            if (bus.upd_type == 2'b10) begin
                ras_d[ras_ptr_q] = bus.upd_pc + XLEN'(4);
                ras_ptr_d        = ras_ptr_q + 1'b1;
                if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + 1'b1;
            end else if (bus.upd_type == 2'b11 && !ras_empty) begin
                ras_ptr_d = ras_ptr_q - 1'b1;
                ras_cnt_d = ras_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
        end else begin
            valid_q   <= valid_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            ctr_q     <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        type_q   <= type_d;
        ras_q    <= ras_d;
    end
endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed self-checking bench for btb_predictor
module tb_btb_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    btb_predictor_if #(.XLEN(32)) bus ();

    btb_predictor #(.XLEN(32), .ENTRIES(16), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
        bus.lk_pc = pc;
        #1;
        check({tag, ".taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_taken});
        check({tag, ".target"}, bus.pred_target, exp_tgt);
        check({tag, ".plus4"}, bus.pred_target_plus4, exp_tgt + 32'd4);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic taken, input logic [1:0] typ);
        @(negedge clk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = taken;
        bus.upd_type   = typ;
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
    endtask

    logic [31:0] ras_exp [4];

    initial begin
        ras_exp[0] = 32'h54; ras_exp[1] = 32'h44; ras_exp[2] = 32'h34; ras_exp[3] = 32'h24;
        bus.flush = 1'b0; bus.lk_pc = '0; bus.upd_valid = 1'b0;
        bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0; bus.upd_type = 2'b00;

        look("in_reset", 32'h100, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        look("after_reset", 32'h100, 1'b0, 32'h0);

        // Direction counter walk on a conditional branch
        upd(32'h100, 32'h180, 1'b1, 2'b00); look("alloc", 32'h100, 1'b1, 32'h180);
        upd(32'h100, 32'h180, 1'b0, 2'b00); look("ctr01", 32'h100, 1'b0, 32'h180);
        upd(32'h100, 32'h180, 1'b0, 2'b00); look("ctr00", 32'h100, 1'b0, 32'h180);
        upd(32'h100, 32'h180, 1'b0, 2'b00); look("ctr00_sat", 32'h100, 1'b0, 32'h180);
        upd(32'h100, 32'h180, 1'b1, 2'b00); look("ctr01_up", 32'h100, 1'b0, 32'h180);
        upd(32'h100, 32'h180, 1'b1, 2'b00); look("ctr10_up", 32'h100, 1'b1, 32'h180);
        upd(32'h100, 32'h180, 1'b1, 2'b00);
        upd(32'h100, 32'h180, 1'b1, 2'b00);
        upd(32'h100, 32'h180, 1'b0, 2'b00); look("ctr11_sat", 32'h100, 1'b1, 32'h180);

        // Aliasing at index 0
        upd(32'h140, 32'h200, 1'b1, 2'b00);
        look("alias_evicted", 32'h100, 1'b0, 32'h0);
        look("alias_new", 32'h140, 1'b1, 32'h200);
        upd(32'h180, 32'h300, 1'b0, 2'b00);
        look("nt_miss_noalloc", 32'h180, 1'b0, 32'h0);
        look("nt_miss_keeps", 32'h140, 1'b1, 32'h200);

        // Same-cycle lookup and update: old value now, new value next cycle
        @(negedge clk);
        bus.lk_pc = 32'h140; bus.upd_valid = 1'b1; bus.upd_pc = 32'h140;
        bus.upd_target = 32'h240; bus.upd_taken = 1'b1; bus.upd_type = 2'b00;
        #1 check("same_cycle_old", bus.pred_target, 32'h200);
        @(posedge clk);
        #1 bus.upd_valid = 1'b0;
        look("same_cycle_new", 32'h140, 1'b1, 32'h240);

        // Call / return
        upd(32'h810, 32'h900, 1'b0, 2'b11);
        look("ret_empty_ras", 32'h810, 1'b1, 32'h900);
        upd(32'h400, 32'h800, 1'b0, 2'b10);
        look("ret_from_ras", 32'h810, 1'b1, 32'h404);
        look("call_entry", 32'h400, 1'b1, 32'h800);
        upd(32'h810, 32'h900, 1'b1, 2'b11);
        look("ret_after_pop", 32'h810, 1'b1, 32'h900);

        // RAS overflow: return entry at index 1, calls land on indices 0/4/8/12
        upd(32'h904, 32'hA00, 1'b1, 2'b11);
        for (int i = 1; i <= 5; i++) upd(32'h10 * i, 32'h2000, 1'b1, 2'b10);
        for (int i = 0; i < 4; i++) begin
            look($sformatf("ovf_pop%0d", i), 32'h904, 1'b1, ras_exp[i]);
            upd(32'h904, 32'hA00, 1'b1, 2'b11);
        end
        look("ovf_drained", 32'h904, 1'b1, 32'hA00);
        upd(32'h904, 32'hA00, 1'b1, 2'b11);
        look("pop_empty_noop", 32'h904, 1'b1, 32'hA00);
        upd(32'h60, 32'h2000, 1'b1, 2'b10);
        look("push_after_empty", 32'h904, 1'b1, 32'h64);
        upd(32'h904, 32'hA00, 1'b1, 2'b11);
        look("pop_after_empty", 32'h904, 1'b1, 32'hA00);

        // Indirect jump: bit 0 cleared; plus4 wraps
        upd(32'h1000, 32'h1235, 1'b0, 2'b01);
        look("jalr_bit0", 32'h1000, 1'b1, 32'h1234);
        upd(32'h2000, 32'hFFFF_FFFC, 1'b1, 2'b01);
        look("plus4_wrap", 32'h2000, 1'b1, 32'hFFFF_FFFC);

        // Flush with a simultaneous update
        upd(32'h3000, 32'h3100, 1'b1, 2'b10);
        @(negedge clk);
        bus.flush = 1'b1; bus.upd_valid = 1'b1; bus.upd_pc = 32'h1004;
        bus.upd_target = 32'h5000; bus.upd_taken = 1'b1; bus.upd_type = 2'b00;
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.upd_valid = 1'b0;
        look("flush_1000", 32'h1000, 1'b0, 32'h0);
        look("flush_2000", 32'h2000, 1'b0, 32'h0);
        look("flush_upd_dropped", 32'h1004, 1'b0, 32'h0);
        upd(32'h904, 32'hA00, 1'b1, 2'b11);
        look("flush_ras_empty", 32'h904, 1'b1, 32'hA00);

        // Asynchronous reset mid-cycle
        upd(32'h100, 32'h180, 1'b1, 2'b00);
        look("pre_async", 32'h100, 1'b1, 32'h180);
        #2 rst = 1'b1;
        #1 check("async_rst_taken", {31'd0, bus.pred_taken}, 32'd0);
        check("async_rst_plus4", bus.pred_target_plus4, 32'h4);
        @(negedge clk);
        rst = 1'b0;
        look("post_async", 32'h100, 1'b0, 32'h0);
        look("post_async_ras", 32'h904, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
